dmem_ctrl: RTL

Data-memory access controller placed between the pipeline MEM stage, a burst DMA/loader port and the single-port word-addressed data memory (256 x 32, combinational read, write on rising clk). It arbitrates the one memory slot per cycle between the two requesters, with CPU priority and a starvation bound. It performs sub-word stores as a single-cycle read-merge-write. It sequences DMA bursts with an auto-incrementing word address.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_store_merge.sv | 24 ++
 rtl/dmem_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access controller.
package dmem_pkg;

  localparam int IDX_W = 8;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_store_merge.sv
// Lane merge for sub-word stores: replaces the addressed byte/half of the old word.
module dmem_store_merge
  import dmem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (size)
      SZ_B: merged[{addr_lo, 3'b000} +: 8] = new_data[7:0];
      SZ_H: begin
        if (addr_lo[1]) merged[31:16] = new_data[15:0];
        else            merged[15:0]  = new_data[15:0];
      end
      default: merged = new_data;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: CPU/DMA slot arbitration with starvation bound and DMA burst sequencing.
// Optional DMEM_CTRL_MISALIGN_EN adds misaligned-store suppression and a sticky err output.
//
// state | meaning
// IDLE  | no burst, waiting for b_start
// BURST | burst active, DMA competes for memory slots
// DONE  | one-cycle b_done pulse after the last beat
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int MAX_CPU_RUN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [1:0]  a_size,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic [31:0] a_rdata,
  output logic        a_ack,
  input  logic        b_start,
  input  logic        b_we,
  input  logic [31:0] b_base,
  input  logic [7:0]  b_len,
  input  logic [31:0] b_wdata,
  input  logic        b_wvalid,
  output logic        b_wready,
  output logic [31:0] b_rdata,
  output logic        b_rvalid,
  output logic        b_busy,
  output logic        b_done,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
`ifdef DMEM_CTRL_MISALIGN_EN
 ,output logic        err
`endif
);

  localparam logic [3:0] RUN_MAX = 4'(MAX_CPU_RUN);

  state_e              state, state_nxt;
  logic                dir_we;
  logic [31-IDX_W-2:0] addr_hi;
  logic [IDX_W-1:0]    idx;
  logic [7:0]          cnt;
  logic [3:0]          cpu_run;
  logic                dma_wait, dma_gnt, cpu_gnt, misalign;
  logic [31:0]         merged;

  assign dma_wait = (state == BURST) && (!dir_we || b_wvalid);
  assign dma_gnt  = dma_wait && (!a_req || cpu_run == RUN_MAX);
  assign cpu_gnt  = a_req && !dma_gnt;

`ifdef DMEM_CTRL_MISALIGN_EN
  assign misalign = ((a_size == SZ_H) && a_addr[0]) || (a_size[1] && (a_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  dmem_store_merge u_merge (
    .old_word (mem_rdata),
    .new_data (a_wdata),
    .size     (a_size),
    .addr_lo  (a_addr[1:0]),
    .merged   (merged)
  );

  assign a_rdata   = mem_rdata;
  assign a_ack     = cpu_gnt;
  assign b_wready  = dma_gnt && dir_we;
  assign mem_addr  = dma_gnt ? {addr_hi, idx, 2'b00} : a_addr;
  assign mem_we    = dma_gnt ? dir_we : (cpu_gnt && a_we && !misalign);
  assign mem_wdata = dma_gnt ? b_wdata : merged;
  assign b_busy    = (state != IDLE);
  assign b_done    = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (b_start) state_nxt = BURST;
      BURST:   if (dma_gnt && cnt == 8'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cnt of 0 means 256: it wraps to 255 on the first slot and ends on 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_we   <= 1'b0;
      addr_hi  <= '0;
      idx      <= '0;
      cnt      <= '0;
      cpu_run  <= '0;
      b_rvalid <= 1'b0;
      b_rdata  <= '0;
    end else begin
      if (state == IDLE && b_start) begin
        dir_we  <= b_we;
        addr_hi <= b_base[31:IDX_W+2];
        idx     <= b_base[IDX_W+1:2];
        cnt     <= b_len;
      end else if (dma_gnt) begin
        idx <= idx + 1'b1;
        cnt <= cnt - 1'b1;
      end
      if (dma_gnt || !dma_wait)              cpu_run <= '0;
      else if (cpu_gnt && cpu_run != RUN_MAX) cpu_run <= cpu_run + 4'd1;
      b_rvalid <= dma_gnt && !dir_we;
      if (dma_gnt && !dir_we) b_rdata <= mem_rdata;
    end
  end

`ifdef DMEM_CTRL_MISALIGN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      err <= 1'b0;
    else if (cpu_gnt && misalign) err <= 1'b1;
  end
`endif

endmodule
